// File: rtl/plc_pkg.sv
// Shared definitions for the PLC pump path: pump state encodings, default
// timing constants and the counter-width helper.
package plc_pkg;

  typedef enum logic [1:0] {
    PUMP_OFF  = 2'd0,
    PUMP_ON   = 2'd1,
    PUMP_REST = 2'd2
  } pump_state_t;

  localparam int         DEF_MIN_ON   = 4;
  localparam int         DEF_MIN_OFF  = 4;
  localparam int         DEF_STAGGER  = 2;
  localparam logic [7:0] DEF_TRIP_LVL = 8'd250;

  // Width able to hold the largest of the three timing constants.
  function automatic int cnt_width(input int min_on, input int min_off, input int stagger);
    int m;
    m = min_on;
    if (min_off > m) m = min_off;
    if (stagger > m) m = stagger;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pump_channel.sv
// One pump: OFF/ON/REST state machine with its minimum-run and minimum-rest
// counters. `started` flags the edge on which this pump enters ON.
module pump_channel
  import plc_pkg::*;
#(
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF,
  parameter int CNT_W   = cnt_width(DEF_MIN_ON, DEF_MIN_OFF, DEF_STAGGER)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic want,
  input  logic start_ok,
  input  logic trip,
  output logic run,
  output logic started,
  output logic idle
);

  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(MIN_OFF - 1);

  pump_state_t      state_reg, state_next;
  logic [CNT_W-1:0] on_cnt_reg, on_cnt_next;
  logic [CNT_W-1:0] off_cnt_reg, off_cnt_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= PUMP_OFF;
      on_cnt_reg  <= '0;
      off_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      on_cnt_reg  <= on_cnt_next;
      off_cnt_reg <= off_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    on_cnt_next  = on_cnt_reg;
    off_cnt_next = off_cnt_reg;
    started      = 1'b0;
    case (state_reg)
      PUMP_OFF: begin
        if (want && start_ok) begin
          state_next  = PUMP_ON;
          on_cnt_next = '0;
          started     = 1'b1;
        end
      end
      PUMP_ON: begin
        // A trip cuts the run short; otherwise honour the minimum run time.
        if (trip || (!want && on_cnt_reg >= ON_LIM)) begin
          state_next   = PUMP_REST;
          off_cnt_next = '0;
        end else if (on_cnt_reg != '1) begin
          on_cnt_next = on_cnt_reg + 1'b1;
        end
      end
      PUMP_REST: begin
        if (off_cnt_reg >= OFF_LIM) begin
          state_next = PUMP_OFF;
        end else if (off_cnt_reg != '1) begin
          off_cnt_next = off_cnt_reg + 1'b1;
        end
      end
      default: state_next = PUMP_OFF;
    endcase
  end

  assign run  = (state_reg == PUMP_ON);
  assign idle = (state_reg == PUMP_OFF);

endmodule

// File: rtl/pump_sequencer.sv
// Pump sequencer: turns the PLC request count into lead/lag pump drives with
// staggered starts, lead alternation and a latched overfill trip.
module pump_sequencer
  import plc_pkg::*;
#(
  parameter int         MIN_ON   = DEF_MIN_ON,
  parameter int         MIN_OFF  = DEF_MIN_OFF,
  parameter int         STAGGER  = DEF_STAGGER,
  parameter logic [7:0] TRIP_LVL = DEF_TRIP_LVL
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pump1_req,
  input  logic       pump2_req,
  input  logic [7:0] water_lvl,
  input  logic       fault_clr,
  output logic       pump1,
  output logic       pump2,
  output logic       lead,
  output logic       fault
);

  localparam int CNT_W = cnt_width(MIN_ON, MIN_OFF, STAGGER);

  logic [1:0]       demand;
  logic [1:0]       demand_d_reg;
  logic             lead_reg, lead_next;
  logic             fault_reg, fault_next;
  logic [CNT_W-1:0] stagger_reg, stagger_next;
  logic             trip, want_lead, want_lag, base_ok;
  logic [1:0]       want, qualify, start_ok, run, started, idle;

  assign demand    = {1'b0, pump1_req} + {1'b0, pump2_req};
  assign want_lead = (demand != 2'd0);
  assign want_lag  = (demand == 2'd2);
  assign trip      = (water_lvl >= TRIP_LVL);
  assign base_ok   = !fault_reg && (stagger_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      localparam logic CH_ID = 1'(gi);
      localparam int   OTHER = 1 - gi;

      assign want[gi]    = (lead_reg == CH_ID) ? want_lead : want_lag;
      assign qualify[gi] = idle[gi] && want[gi] && base_ok;
      // When both pumps could start on the same edge, the lead wins.
      assign start_ok[gi] = base_ok && ((lead_reg == CH_ID) || !qualify[OTHER]);

      pump_channel #(
        .MIN_ON  (MIN_ON),
        .MIN_OFF (MIN_OFF),
        .CNT_W   (CNT_W)
      ) u_chan (
        .clock    (clock),
        .reset_n  (reset_n),
        .want     (want[gi]),
        .start_ok (start_ok[gi]),
        .trip     (trip),
        .run      (run[gi]),
        .started  (started[gi]),
        .idle     (idle[gi])
      );
    end
  endgenerate

  always_comb begin
    stagger_next = stagger_reg;
    if (|started) begin
      stagger_next = CNT_W'(STAGGER);
    end else if (stagger_reg != '0) begin
      stagger_next = stagger_reg - 1'b1;
    end
  end

  // Lead swaps at the end of every demand episode.
  assign lead_next  = lead_reg ^ ((demand_d_reg != 2'd0) && (demand == 2'd0));
  assign fault_next = trip ? 1'b1 : (fault_clr ? 1'b0 : fault_reg);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      demand_d_reg <= 2'd0;
      lead_reg     <= 1'b0;
      fault_reg    <= 1'b0;
      stagger_reg  <= '0;
    end else begin
      demand_d_reg <= demand;
      lead_reg     <= lead_next;
      fault_reg    <= fault_next;
      stagger_reg  <= stagger_next;
    end
  end

  assign pump1 = run[0];
  assign pump2 = run[1];
  assign lead  = lead_reg;
  assign fault = fault_reg;

endmodule

// File: tb/tb_pump_sequencer.sv
// Self-checking bench for pump_sequencer: directed scenarios plus random
// traffic, all compared against an edge-count based reference model.
module tb_pump_sequencer;

  localparam int         MIN_ON  = 4;
  localparam int         MIN_OFF = 4;
  localparam int         STAGGER = 2;
  localparam logic [7:0] TRIP    = 8'd250;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       pump1_req = 1'b0;
  logic       pump2_req = 1'b0;
  logic [7:0] water_lvl = 8'd0;
  logic       fault_clr = 1'b0;
  logic       pump1, pump2, lead, fault;

  int checks = 0;
  int passed = 0;

  // Reference model: timestamps of starts/stops instead of states/counters.
  bit m_run [2];
  int m_start [2];
  int m_avail [2];
  int m_last_start;
  bit m_fault;
  bit m_lead;
  int m_dem_d;
  int n;

  always #5 clock = ~clock;

  pump_sequencer #(
    .MIN_ON   (MIN_ON),
    .MIN_OFF  (MIN_OFF),
    .STAGGER  (STAGGER),
    .TRIP_LVL (TRIP)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pump1_req (pump1_req),
    .pump2_req (pump2_req),
    .water_lvl (water_lvl),
    .fault_clr (fault_clr),
    .pump1     (pump1),
    .pump2     (pump2),
    .lead      (lead),
    .fault     (fault)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i]   = 1'b0;
      m_start[i] = 0;
      m_avail[i] = 0;
    end
    m_last_start = -1000;
    m_fault = 1'b0;
    m_lead  = 1'b0;
    m_dem_d = 0;
    n = 0;
  endtask

  task automatic model_edge();
    int dem;
    bit trip;
    bit w [2];
    bit stop [2];
    bit q [2];
    bit go [2];
    dem  = int'(pump1_req) + int'(pump2_req);
    trip = (water_lvl >= TRIP);
    for (int i = 0; i < 2; i++) begin
      w[i]    = (i == int'(m_lead)) ? (dem >= 1) : (dem == 2);
      stop[i] = m_run[i] && (trip || (!w[i] && (n - m_start[i] >= MIN_ON)));
      q[i]    = !m_run[i] && (n >= m_avail[i]) && w[i] && !m_fault
                && (n - m_last_start > STAGGER);
    end
    for (int i = 0; i < 2; i++)
      go[i] = q[i] && ((i == int'(m_lead)) || !q[1-i]);
    for (int i = 0; i < 2; i++) begin
      if (stop[i]) begin
        m_run[i]   = 1'b0;
        m_avail[i] = n + MIN_OFF + 1;
      end
      if (go[i]) begin
        m_run[i]     = 1'b1;
        m_start[i]   = n;
        m_last_start = n;
      end
    end
    m_fault = trip ? 1'b1 : (fault_clr ? 1'b0 : m_fault);
    if (m_dem_d != 0 && dem == 0) m_lead = !m_lead;
    m_dem_d = dem;
    n++;
  endtask

  task automatic step(input logic r1, input logic r2, input logic [7:0] lvl, input logic clr);
    pump1_req = r1;
    pump2_req = r2;
    water_lvl = lvl;
    fault_clr = clr;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pump1_req = 1'b0;
    pump2_req = 1'b0;
    water_lvl = 8'd0;
    fault_clr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({pump1, pump2, lead, fault} !== 4'b0000)
      $display("FAIL reset_held: p1 p2 lead fault=%b required 0000", {pump1, pump2, lead, fault});
    else passed++;
    reset_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 8'd100, 1'b0);
    checks++;
    if ({pump1, pump2, lead, fault} !== 4'b0000)
      $display("FAIL reset_idle: p1 p2 lead fault=%b required 0000", {pump1, pump2, lead, fault});
    else passed++;
  endtask

  task automatic test_single_demand();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'd100, 1'b0);
      checks++;
      if ({pump1, pump2, lead, fault} !== {m_run[0], m_run[1], m_lead, m_fault})
        $display("FAIL single_demand cyc %0d: p1 p2 lead fault=%b required %b", i,
                 {pump1, pump2, lead, fault}, {m_run[0], m_run[1], m_lead, m_fault});
      else passed++;
      if (i == 0) begin
        checks++;
        if ({pump1, pump2, lead} !== 3'b100)
          $display("FAIL single_start_latency: p1 p2 lead=%b required 100", {pump1, pump2, lead});
        else passed++;
      end
    end
  endtask

  task automatic test_min_on();
    int high_cnt;
    do_reset();
    step(1'b1, 1'b0, 8'd100, 1'b0);
    high_cnt = int'(pump1);
    for (int i = 0; i < 14; i++) begin
      if (i >= 5 && i < 10) step(1'b1, 1'b1, 8'd100, 1'b0);
      else step(1'b0, 1'b0, 8'd100, 1'b0);
      if (i < 5) high_cnt += int'(pump1);
      checks++;
      if ({pump1, pump2, lead, fault} !== {m_run[0], m_run[1], m_lead, m_fault})
        $display("FAIL min_on cyc %0d: p1 p2 lead fault=%b required %b", i,
                 {pump1, pump2, lead, fault}, {m_run[0], m_run[1], m_lead, m_fault});
      else passed++;
      if (i == 0) begin
        checks++;
        if (lead !== 1'b1) $display("FAIL lead_toggle: lead=%b required 1", lead);
        else passed++;
      end
    end
    checks++;
    if (high_cnt != MIN_ON)
      $display("FAIL min_on_length: pump1 high %0d cycles required %0d", high_cnt, MIN_ON);
    else passed++;
  endtask

  task automatic test_stagger();
    int r1, r2;
    r1 = -1;
    r2 = -1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 8'd100, 1'b0);
      if (pump1 === 1'b1 && r1 < 0) r1 = i;
      if (pump2 === 1'b1 && r2 < 0) r2 = i;
      checks++;
      if ({pump1, pump2, lead, fault} !== {m_run[0], m_run[1], m_lead, m_fault})
        $display("FAIL stagger cyc %0d: p1 p2 lead fault=%b required %b", i,
                 {pump1, pump2, lead, fault}, {m_run[0], m_run[1], m_lead, m_fault});
      else passed++;
    end
    checks++;
    if (r1 != 0 || r2 < 0 || (r2 - r1) < STAGGER)
      $display("FAIL stagger_gap: lead rise %0d lag rise %0d required 0 and gap >= %0d", r1, r2, STAGGER);
    else passed++;
  endtask

  task automatic test_alternation();
    int exp_pump [3] = '{0, 1, 0};
    int first;
    do_reset();
    for (int ep = 0; ep < 3; ep++) begin
      first = -1;
      for (int i = 0; i < 14; i++) begin
        if (i < 2) step(ep == 1 ? 1'b0 : 1'b1, ep == 1 ? 1'b1 : 1'b0, 8'd90, 1'b0);
        else step(1'b0, 1'b0, 8'd90, 1'b0);
        if (first < 0 && pump1 === 1'b1) first = 0;
        if (first < 0 && pump2 === 1'b1) first = 1;
        checks++;
        if ({pump1, pump2, lead, fault} !== {m_run[0], m_run[1], m_lead, m_fault})
          $display("FAIL alternation ep %0d cyc %0d: p1 p2 lead fault=%b required %b", ep, i,
                   {pump1, pump2, lead, fault}, {m_run[0], m_run[1], m_lead, m_fault});
        else passed++;
      end
      checks++;
      if (first != exp_pump[ep])
        $display("FAIL alternation_order ep %0d: served pump index %0d required %0d", ep, first, exp_pump[ep]);
      else passed++;
    end
  endtask

  task automatic test_trip();
    bit restarted;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'd100, 1'b0);
    step(1'b1, 1'b1, 8'd249, 1'b0);
    checks++;
    if ({pump1, pump2, fault} !== 3'b110)
      $display("FAIL trip_below: p1 p2 fault=%b required 110", {pump1, pump2, fault});
    else passed++;
    step(1'b1, 1'b1, 8'd250, 1'b0);
    checks++;
    if ({pump1, pump2, fault} !== 3'b001)
      $display("FAIL trip_edge: p1 p2 fault=%b required 001", {pump1, pump2, fault});
    else passed++;
    step(1'b1, 1'b1, 8'd250, 1'b1);
    checks++;
    if (fault !== 1'b1) $display("FAIL clear_blocked: fault=%b required 1", fault);
    else passed++;
    step(1'b1, 1'b1, 8'd200, 1'b1);
    checks++;
    if (fault !== 1'b0) $display("FAIL clear_ok: fault=%b required 0", fault);
    else passed++;
    restarted = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 8'd200, 1'b0);
      if (pump1 === 1'b1 || pump2 === 1'b1) restarted = 1'b1;
      checks++;
      if ({pump1, pump2, lead, fault} !== {m_run[0], m_run[1], m_lead, m_fault})
        $display("FAIL trip_recover cyc %0d: p1 p2 lead fault=%b required %b", i,
                 {pump1, pump2, lead, fault}, {m_run[0], m_run[1], m_lead, m_fault});
      else passed++;
    end
    checks++;
    if (!restarted) $display("FAIL trip_restart: pumps idle=1 required a restart");
    else passed++;
  endtask

  task automatic test_random();
    logic r1, r2, clr;
    logic [7:0] lvl;
    r1 = 1'b0;
    r2 = 1'b0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) r2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) lvl = 8'($urandom_range(248, 255));
      else lvl = 8'($urandom_range(0, 249));
      clr = ($urandom_range(0, 5) == 0);
      step(r1, r2, lvl, clr);
      checks++;
      if ({pump1, pump2, lead, fault} !== {m_run[0], m_run[1], m_lead, m_fault})
        $display("FAIL random cyc %0d: p1 p2 lead fault=%b required %b", i,
                 {pump1, pump2, lead, fault}, {m_run[0], m_run[1], m_lead, m_fault});
      else passed++;
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    step(1'b1, 1'b0, 8'd100, 1'b0);
    step(1'b1, 1'b0, 8'd100, 1'b0);
    checks++;
    if (pump1 !== 1'b1) $display("FAIL midrun_setup: pump1=%b required 1", pump1);
    else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pump1 !== 1'b0) $display("FAIL midrun_async_drop: pump1=%b required 0", pump1);
    else passed++;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 8'd100, 1'b0);
    checks++;
    if ({pump1, pump2, lead, fault} !== 4'b0000)
      $display("FAIL midrun_release: p1 p2 lead fault=%b required 0000", {pump1, pump2, lead, fault});
    else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_demand();
    test_min_on();
    test_stagger();
    test_alternation();
    test_trip();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
